cmplt_arbiter: RTL and testbench

//  Shares the completion/wakeup bus between execution units. Up to NUM_UNITS

---
 rtl/cmplt_arbiter_pkg.sv | 12 +
 rtl/cmplt_arbiter_rr_select.sv | 40 ++++
 rtl/cmplt_arbiter.sv | 105 ++++++++++
 tb/tb_cmplt_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/cmplt_arbiter_pkg.sv
// Shared widths for the completion/wakeup bus between the execution units
// and the frontend.
package cmplt_arbiter_pkg;

    localparam int PR_ADDR_W     = 6;
    localparam int PHYS_REGS     = 1 << PR_ADDR_W;
    localparam int CMPLT_WIDTH   = 5;
    localparam int ARCH_REG_W    = 4;
    localparam int PR_NULL_LIMIT = 2;
    localparam int NUM_UNITS     = 8;

endpackage

// File: rtl/cmplt_arbiter_rr_select.sv
// Rotating-priority selector: picks the first K requesters of N, starting
// the scan at ptr and wrapping.
module rr_select #(
    parameter int N  = 8,
    parameter int K  = 5,
    parameter int IW = $clog2(N),
    parameter int CW = $clog2(K + 1)
) (
    input  logic [N-1:0]          req,
    input  logic [IW-1:0]         ptr,
    output logic [N-1:0]          grant,
    output logic [K-1:0][IW-1:0]  slot_idx,
    output logic [K-1:0]          slot_vld,
    output logic [CW-1:0]         n_grant,
    output logic [IW-1:0]         last_idx
);

    always_comb begin
        logic [CW-1:0] cnt;
        logic [IW-1:0] u;
        grant    = '0;
        slot_idx = '0;
        slot_vld = '0;
        last_idx = '0;
        cnt      = '0;
        u        = '0;
        for (int i = 0; i < N; i++) begin
            u = IW'((int'(ptr) + i) % N);
            if (req[u] && cnt < CW'(K)) begin
                grant[u]      = 1'b1;
                slot_idx[cnt] = u;
                slot_vld[cnt] = 1'b1;
                last_idx      = u;
                cnt           = cnt + CW'(1);
            end
        end
        n_grant = cnt;
    end

endmodule

// File: rtl/cmplt_arbiter.sv
// Completion bus arbiter: grants up to CMPLT_WIDTH unit completions per cycle
// round-robin and publishes them on registered slots one cycle later.
module cmplt_arbiter
    import cmplt_arbiter_pkg::*;
#(
    parameter int NUM_UNITS_P = NUM_UNITS,
    parameter int CMPLT_W     = CMPLT_WIDTH,
    parameter int ARCH_W      = ARCH_REG_W,
    parameter int PR_W        = PR_ADDR_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_UNITS_P-1:0]      req_valid,
    output logic [NUM_UNITS_P-1:0]      req_ready,
    input  logic [NUM_UNITS_P*ARCH_W-1:0] req_arch,
    input  logic [NUM_UNITS_P*PR_W-1:0] req_phys,
    input  logic                        hold,
    output logic [CMPLT_W-1:0]          cmplt_valid,
    output logic [CMPLT_W*ARCH_W-1:0]   cmplt_dest_arch,
    output logic [CMPLT_W*PR_W-1:0]     cmplt_dest_phys,
    output logic [$clog2(CMPLT_W+1)-1:0] cmplt_count,
    output logic [15:0]                 stall_cycles
);

    localparam int UW = $clog2(NUM_UNITS_P);
    localparam int CW = $clog2(CMPLT_W + 1);

    logic [NUM_UNITS_P-1:0][ARCH_W-1:0] arch_v;
    logic [NUM_UNITS_P-1:0][PR_W-1:0]   phys_v;
    logic [NUM_UNITS_P-1:0]             is_null;
    logic [NUM_UNITS_P-1:0]             real_req;
    logic [NUM_UNITS_P-1:0]             grant;
    logic [CMPLT_W-1:0][UW-1:0]         slot_idx;
    logic [CMPLT_W-1:0]                 slot_vld;
    logic [CW-1:0]                      n_grant;
    logic [UW-1:0]                      last_idx;
    logic [UW-1:0]                      rr_ptr;
    logic                               open;

    logic [CMPLT_W-1:0][ARCH_W-1:0]     arch_q;
    logic [CMPLT_W-1:0][PR_W-1:0]       phys_q;
    logic [15:0]                        stall_q;

    assign arch_v = req_arch;
    assign phys_v = req_phys;
    assign open   = ~rst & ~hold;

    // Null-dest requests are acked freely but never take a slot.
    always_comb begin
        for (int u = 0; u < NUM_UNITS_P; u++)
            is_null[u] = phys_v[u] < PR_W'(PR_NULL_LIMIT);
    end

    assign real_req  = req_valid & ~is_null & {NUM_UNITS_P{open}};
    assign req_ready = {NUM_UNITS_P{open}} &
                       (grant | (req_valid & is_null));

    rr_select #(
        .N  (NUM_UNITS_P),
        .K  (CMPLT_W),
        .IW (UW),
        .CW (CW)
    ) u_sel (
        .req      (real_req),
        .ptr      (rr_ptr),
        .grant    (grant),
        .slot_idx (slot_idx),
        .slot_vld (slot_vld),
        .n_grant  (n_grant),
        .last_idx (last_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr      <= '0;
            cmplt_valid <= '0;
            arch_q      <= '0;
            phys_q      <= '0;
            cmplt_count <= '0;
            stall_q     <= '0;
        end else begin
            for (int s = 0; s < CMPLT_W; s++) begin
                if (slot_vld[s]) begin
                    arch_q[s] <= arch_v[slot_idx[s]];
                    phys_q[s] <= phys_v[slot_idx[s]];
                end else begin
                    arch_q[s] <= '0;
                    phys_q[s] <= '0;
                end
            end
            cmplt_valid <= slot_vld;
            cmplt_count <= n_grant;
            if (n_grant != '0)
                rr_ptr <= (last_idx == UW'(NUM_UNITS_P - 1)) ?
                          '0 : last_idx + UW'(1);
            if (|(req_valid & ~req_ready) && stall_q != 16'hFFFF)
                stall_q <= stall_q + 16'd1;
        end
    end

    assign cmplt_dest_arch = arch_q;
    assign cmplt_dest_phys = phys_q;
    assign stall_cycles    = stall_q;

endmodule

// File: tb/tb_cmplt_arbiter.sv
// Bench for cmplt_arbiter: directed vector table, saturation sequence and
// randomized traffic against a queue-based reference model.
module tb_cmplt_arbiter;

    localparam int NU = 8;
    localparam int K  = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              hold;
    logic [7:0]        req_valid;
    logic [7:0]        req_ready;
    logic [7:0][3:0]   ar_a;
    logic [7:0][5:0]   ph_a;
    logic [4:0]        cmplt_valid;
    logic [19:0]       cmplt_dest_arch;
    logic [29:0]       cmplt_dest_phys;
    logic [2:0]        cmplt_count;
    logic [15:0]       stall_cycles;

    always #5 clk = ~clk;

    cmplt_arbiter dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_arch        (ar_a),
        .req_phys        (ph_a),
        .hold            (hold),
        .cmplt_valid     (cmplt_valid),
        .cmplt_dest_arch (cmplt_dest_arch),
        .cmplt_dest_phys (cmplt_dest_phys),
        .cmplt_count     (cmplt_count),
        .stall_cycles    (stall_cycles)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    int             m_ptr;
    logic [4:0]     m_valid;
    logic [4:0][3:0] m_arch;
    logic [4:0][5:0] m_phys;
    int             m_count;
    int             m_stall;
    int             gq[$];

    typedef struct {
        string          name;
        logic           rst;
        logic           hold;
        logic [7:0]     valid;
        logic [7:0][5:0] phys;
        logic [7:0]     exp_ready;
        int             exp_count;
    } vec_t;

    vec_t tbl[9];

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0][5:0] dflt_phys();
        logic [7:0][5:0] p;
        for (int u = 0; u < NU; u++) p[u] = 6'(10 + u);
        return p;
    endfunction

    // One cycle: drive at negedge, check ready, clock, check published state.
    task automatic step(input string nm, input logic r, input logic h,
                        input logic [7:0] v, output logic [7:0] act_rdy);
        logic [7:0] rdy;
        int u;
        rst       = r;
        hold      = h;
        req_valid = v;
        #1;
        rdy = '0;
        gq.delete();
        if (!r && !h) begin
            for (int i = 0; i < NU; i++) begin
                u = (m_ptr + i) % NU;
                if (v[u]) begin
                    if (ph_a[u] < 2) rdy[u] = 1'b1;
                    else if (gq.size() < K) begin
                        gq.push_back(u);
                        rdy[u] = 1'b1;
                    end
                end
            end
        end
        act_rdy = req_ready;
        check({nm, "_ready"}, 64'(req_ready), 64'(rdy));
        m_valid = '0;
        m_arch  = '0;
        m_phys  = '0;
        if (r) begin
            m_ptr   = 0;
            m_count = 0;
            m_stall = 0;
        end else begin
            foreach (gq[s]) begin
                m_valid[s] = 1'b1;
                m_arch[s]  = ar_a[gq[s]];
                m_phys[s]  = ph_a[gq[s]];
            end
            m_count = gq.size();
            if (gq.size() > 0) m_ptr = (gq[gq.size()-1] + 1) % NU;
            if ((v & ~rdy) != 0 && m_stall < 16'hFFFF) m_stall++;
        end
        @(posedge clk);
        #1;
        check({nm, "_valid"}, 64'(cmplt_valid), 64'(m_valid));
        check({nm, "_arch"}, 64'(cmplt_dest_arch), 64'(m_arch));
        check({nm, "_phys"}, 64'(cmplt_dest_phys), 64'(m_phys));
        check({nm, "_count"}, 64'(cmplt_count), 64'(m_count));
        check({nm, "_stall"}, 64'(stall_cycles), 64'(m_stall));
        @(negedge clk);
    endtask

    initial begin
        logic [7:0]      rdy;
        logic [7:0][5:0] p;
        rst = 1'b1; hold = 1'b0; req_valid = '0;
        for (int u = 0; u < NU; u++) ar_a[u] = 4'(u + 1);
        ph_a = dflt_phys();
        m_ptr = 0; m_valid = '0; m_arch = '0; m_phys = '0;
        m_count = 0; m_stall = 0;

        p = dflt_phys();
        tbl[0] = '{"rst0",  1'b1, 1'b0, 8'hFF, p, 8'h00, 0};
        tbl[1] = '{"rst1",  1'b1, 1'b0, 8'hFF, p, 8'h00, 0};
        tbl[2] = '{"three", 1'b0, 1'b0, 8'h07, p, 8'h07, 3};
        tbl[3] = '{"rst2",  1'b1, 1'b0, 8'h00, p, 8'h00, 0};
        tbl[4] = '{"all_a", 1'b0, 1'b0, 8'hFF, p, 8'h1F, 5};
        tbl[5] = '{"all_b", 1'b0, 1'b0, 8'hFF, p, 8'hE3, 5};
        p[2] = 6'd1; p[3] = 6'd9;
        tbl[6] = '{"nulld", 1'b0, 1'b0, 8'h0C, p, 8'h0C, 1};
        p = dflt_phys();
        tbl[7] = '{"hold",  1'b0, 1'b1, 8'h0F, p, 8'h00, 0};
        tbl[8] = '{"unhld", 1'b0, 1'b0, 8'h0F, p, 8'h0F, 4};

        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            ph_a = tbl[i].phys;
            step(tbl[i].name, tbl[i].rst, tbl[i].hold, tbl[i].valid, rdy);
            check({tbl[i].name, "_tbl_ready"}, 64'(rdy),
                  64'(tbl[i].exp_ready));
            check({tbl[i].name, "_tbl_count"}, 64'(cmplt_count),
                  64'(tbl[i].exp_count));
        end

        // saturation of the stall counter
        ph_a = dflt_phys();
        dut.stall_q = 16'hFFFD;
        m_stall = 16'hFFFD;
        for (int i = 0; i < 3; i++) step("sat", 1'b0, 1'b1, 8'hFF, rdy);
        check("stall_sat", 64'(stall_cycles), 64'hFFFF);
        step("sat_idle", 1'b0, 1'b0, 8'h00, rdy);
        check("stall_sat_idle", 64'(stall_cycles), 64'hFFFF);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            for (int u = 0; u < NU; u++) begin
                ar_a[u] = 4'($urandom);
                ph_a[u] = ($urandom_range(0, 3) == 0) ?
                          6'($urandom_range(0, 1)) : 6'($urandom);
            end
            step("rand", $urandom_range(0, 49) == 0,
                 $urandom_range(0, 9) == 0, 8'($urandom), rdy);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
